// File: rtl/immediate_encoder_pipe.sv
// Two-stage valid/ready pipeline that packs an immediate into an RV32I I/S/B/U/J instruction word,
// flags unrepresentable or misaligned immediates, and keeps delivery/error statistics.
module immediate_encoder_pipe #(
  parameter int N     = 32,
  parameter int K     = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [K-1:0]     i_imm_sel,
  input  logic [N-1:0]     i_imm_value,
  input  logic [N-1:0]     i_base_instr,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [N-1:0]     o_instr_out,
  output logic             o_range_err,
  output logic             o_err_sticky,
  output logic [CNT_W-1:0] o_enc_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam logic [K-1:0] SEL_I = K'(0);
  localparam logic [K-1:0] SEL_S = K'(1);
  localparam logic [K-1:0] SEL_B = K'(2);
  localparam logic [K-1:0] SEL_U = K'(3);
  localparam logic [K-1:0] SEL_J = K'(4);

  logic             r_s1_valid;
  logic [N-1:0]     r_s1_base;
  logic [K-1:0]     r_s1_sel;
  logic [N-1:0]     r_s1_imm;
  logic             r_s1_err;

  logic             r_s2_valid;
  logic [N-1:0]     r_instr_out;
  logic             r_range_err;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_enc_count;
  logic [CNT_W-1:0] r_err_count;

  logic             w_s2_load;
  logic             w_s1_adv;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_err1;
  logic [N-1:0]     w_instr;

  assign w_s2_load  = !r_s2_valid || i_out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_load;
  assign o_in_ready = !r_s1_valid || w_s1_adv;
  assign w_in_fire  = i_in_valid && o_in_ready;
  assign w_out_fire = r_s2_valid && i_out_ready;

  // Range check on the raw request: upper bits must replicate the format's sign bit.
  always_comb begin
    w_err1 = 1'b1;
    case (i_imm_sel)
      SEL_I, SEL_S: w_err1 = (i_imm_value[N-1:12] != {(N-12){i_imm_value[11]}});
      SEL_B:        w_err1 = i_imm_value[0] ||
                             (i_imm_value[N-1:13] != {(N-13){i_imm_value[12]}});
      SEL_U:        w_err1 = (i_imm_value[11:0] != 12'd0);
      SEL_J:        w_err1 = i_imm_value[0] ||
                             (i_imm_value[N-1:21] != {(N-21){i_imm_value[20]}});
      default:      w_err1 = 1'b1;
    endcase
  end

  // Scatter the immediate over the base word; out-of-range values are simply truncated.
  always_comb begin
    w_instr = r_s1_base;
    case (r_s1_sel)
      SEL_I: w_instr[31:20] = r_s1_imm[11:0];
      SEL_S: begin
        w_instr[31:25] = r_s1_imm[11:5];
        w_instr[11:7]  = r_s1_imm[4:0];
      end
      SEL_B: begin
        w_instr[31]    = r_s1_imm[12];
        w_instr[30:25] = r_s1_imm[10:5];
        w_instr[11:8]  = r_s1_imm[4:1];
        w_instr[7]     = r_s1_imm[11];
      end
      SEL_U: w_instr[31:12] = r_s1_imm[31:12];
      SEL_J: begin
        w_instr[31]    = r_s1_imm[20];
        w_instr[30:21] = r_s1_imm[10:1];
        w_instr[20]    = r_s1_imm[11];
        w_instr[19:12] = r_s1_imm[19:12];
      end
      default: w_instr = r_s1_base;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_base  <= '0;
      r_s1_sel   <= '0;
      r_s1_imm   <= '0;
      r_s1_err   <= 1'b0;
    end else if (o_in_ready) begin
      r_s1_valid <= i_in_valid;
      if (i_in_valid) begin
        r_s1_base <= i_base_instr;
        r_s1_sel  <= i_imm_sel;
        r_s1_imm  <= i_imm_value;
        r_s1_err  <= w_err1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_instr_out <= '0;
      r_range_err <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_instr_out <= w_instr;
        r_range_err <= r_s1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
      r_enc_count  <= '0;
      r_err_count  <= '0;
    end else if (w_out_fire) begin
      r_enc_count <= r_enc_count + CNT_W'(1);
      if (r_range_err) begin
        r_err_sticky <= 1'b1;
        if (r_err_count != {CNT_W{1'b1}}) r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign o_out_valid  = r_s2_valid;
  assign o_instr_out  = r_instr_out;
  assign o_range_err  = r_range_err;
  assign o_err_sticky = r_err_sticky;
  assign o_enc_count  = r_enc_count;
  assign o_err_count  = r_err_count;

  // Keep w_in_fire observable for readers; it documents the accept condition.
  logic w_unused;
  assign w_unused = w_in_fire;

endmodule
